// File: rtl/aes128_enc_seq.sv
// AES-128 block encryption sequencer driving a combinational 64-bit AES unit.
// Round keys are generated on the fly; five unit ops per round, ten rounds.
module aes128_enc_seq (
  input  logic         g_clk,
  input  logic         g_resetn,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [127:0] req_key,
  input  logic [127:0] req_pt,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_ct,
  output logic         aes_valid,
  input  logic         aes_ready,
  output logic         aes_mix,
  output logic         aes_op_enc,
  output logic         aes_op_ks1,
  output logic         aes_op_ks2,
  output logic [63:0]  aes_rs1,
  output logic [63:0]  aes_rs2,
  input  logic [63:0]  aes_rd
);

  typedef enum logic [2:0] {
    StIdle,
    StKs1,
    StKs2L,
    StKs2H,
    StEncL,
    StEncH,
    StDone
  } state_e;

  state_e       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] s_q, s_d;
  logic [127:0] k_q, k_d;
  logic [63:0]  t_lo_q, t_lo_d;
  logic [63:0]  w_q, w_d;

  logic fire;
  logic last_round;

  assign fire       = aes_valid & aes_ready;
  assign last_round = (rnd_q == 4'd10);

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    s_d     = s_q;
    k_d     = k_q;
    t_lo_d  = t_lo_q;
    w_d     = w_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          k_d     = req_key;
          s_d     = req_pt ^ req_key;
          rnd_d   = 4'd1;
          state_d = StKs1;
        end
      end
      StKs1: begin
        if (fire) begin
          w_d     = aes_rd;
          state_d = StKs2L;
        end
      end
      StKs2L: begin
        if (fire) begin
          k_d[63:0] = aes_rd;
          state_d   = StKs2H;
        end
      end
      StKs2H: begin
        if (fire) begin
          k_d[127:64] = aes_rd;
          state_d     = StEncL;
        end
      end
      StEncL: begin
        if (fire) begin
          t_lo_d  = aes_rd;
          state_d = StEncH;
        end
      end
      StEncH: begin
        if (fire) begin
          // AddRoundKey folded into the write-back of both state halves
          s_d = {aes_rd ^ k_q[127:64], t_lo_q ^ k_q[63:0]};
          if (last_round) begin
            state_d = StDone;
          end else begin
            rnd_d   = rnd_q + 4'd1;
            state_d = StKs1;
          end
        end
      end
      StDone: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= StIdle;
      rnd_q   <= 4'd0;
      s_q     <= '0;
      k_q     <= '0;
      t_lo_q  <= '0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      s_q     <= s_d;
      k_q     <= k_d;
      t_lo_q  <= t_lo_d;
      w_q     <= w_d;
    end
  end

  // All outputs are decoded from registered state only.
  always_comb begin
    req_ready  = (state_q == StIdle);
    rsp_valid  = (state_q == StDone);
    rsp_ct     = s_q;
    aes_valid  = 1'b0;
    aes_mix    = 1'b0;
    aes_op_enc = 1'b0;
    aes_op_ks1 = 1'b0;
    aes_op_ks2 = 1'b0;
    aes_rs1    = '0;
    aes_rs2    = '0;
    unique case (state_q)
      StKs1: begin
        aes_valid  = 1'b1;
        aes_op_ks1 = 1'b1;
        aes_rs1    = k_q[127:64];
        aes_rs2    = {60'd0, rnd_q - 4'd1};
      end
      StKs2L: begin
        aes_valid  = 1'b1;
        aes_op_ks2 = 1'b1;
        aes_rs1    = w_q;
        aes_rs2    = k_q[63:0];
      end
      StKs2H: begin
        aes_valid  = 1'b1;
        aes_op_ks2 = 1'b1;
        aes_rs1    = k_q[63:0];
        aes_rs2    = k_q[127:64];
      end
      StEncL: begin
        aes_valid  = 1'b1;
        aes_op_enc = 1'b1;
        aes_mix    = ~last_round;
        aes_rs1    = s_q[63:0];
        aes_rs2    = s_q[127:64];
      end
      StEncH: begin
        aes_valid  = 1'b1;
        aes_op_enc = 1'b1;
        aes_mix    = ~last_round;
        aes_rs1    = s_q[127:64];
        aes_rs2    = s_q[63:0];
      end
      default: ;
    endcase
  end

endmodule
